// File: rtl/crctab_pkg.sv
// crctab_pkg: shared constants and state encoding for the CRC-32 table
// generator and anything that reuses its shift-step helper.
//   CRC32_POLY_ETH : standard Ethernet CRC-32 generator, implicit x^32 term
//   TAB_ENTRIES    : number of byte-table entries
//   TAB_ADDR_BITS  : address width of the byte table
//   state_t        : generator FSM states (CHECK is only reachable when the
//                    self-check build option is enabled)
package crctab_pkg;

    localparam logic [31:0] CRC32_POLY_ETH = 32'h04C11DB7;
    localparam int          TAB_ENTRIES    = 256;
    localparam int          TAB_ADDR_BITS  = 8;

    typedef enum logic [1:0] {
        CALC  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/crc_shift_step.sv
// crc_shift_step: purely combinational MSB-first CRC shift. Applies BPC
// iterations of  w = w[31] ? (w << 1) ^ POLY : (w << 1)  to din.
// Ports:
//   din  in  32  word before shifting
//   dout out 32  word after BPC shift steps
module crc_shift_step #(
    parameter logic [31:0] POLY = 32'h04C11DB7,
    parameter int          BPC  = 1
) (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    logic [31:0] w;

    always_comb begin
        w = din;
        for (int i = 0; i < BPC; i++) begin
            w = w[31] ? ((w << 1) ^ POLY) : (w << 1);
        end
        dout = w;
    end

endmodule

// File: rtl/crctab_gen.sv
// crctab_gen: builds the 256-entry MSB-first (non-reflected) CRC-32 byte
// table at runtime with a bit-serial shift/XOR FSM, then serves lookups.
// Build option: CRCTAB_GEN_SELFCHECK_EN adds a one-clock CHECK state after
// generation that verifies entries 0 and 1 and raises a sticky chk_err.
// Ports:
//   clk       in   1   system clock
//   rstn      in   1   asynchronous active-low reset
//   regen     in   1   pulse to rebuild the table; honoured only in DONE
//   addr      in   32  lookup address; only addr[7:0] is used
//   rdata     out  32  mem[addr[7:0]] when done=1, else 0 (combinational)
//   done      out  1   table valid
//   busy      out  1   generation (or self-check) in progress
//   chk_err   out  1   self-check failure flag (constant 0 without the option)
//   state_dbg out  2   current FSM state, for observation only
// Interface contract: there is no backpressure. The consumer treats done as
// the "valid" of the whole table and must only use rdata while done=1;
// regen acts as a single-cycle request that is accepted only while done=1
// and is dropped (not queued) otherwise.
module crctab_gen
    import crctab_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY_ETH,
    parameter int          BPC  = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        regen,
    input  logic [31:0] addr,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        chk_err,
    output logic [1:0]  state_dbg
);

    localparam int         STEPS     = 8 / BPC;
    localparam logic [3:0] STEP_LAST = 4'(STEPS - 1);

    state_t                     state, state_nx;
    logic [TAB_ADDR_BITS-1:0]   idx;
    logic [TAB_ADDR_BITS-1:0]   idx_inc;
    logic [3:0]                 step;
    logic [31:0]                work;
    logic [31:0]                work_next;
    logic                       entry_end;
    logic [31:0]                mem [TAB_ENTRIES];

    // Upper address bits are deliberately ignored by the lookup.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:TAB_ADDR_BITS];

    crc_shift_step #(
        .POLY (POLY),
        .BPC  (BPC)
    ) u_shift (
        .din  (work),
        .dout (work_next)
    );

    assign idx_inc   = idx + 8'd1;
    assign entry_end = (state == CALC) && (step == STEP_LAST);

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            CALC: begin
                if (entry_end && (idx == 8'hFF)) begin
`ifdef CRCTAB_GEN_SELFCHECK_EN
                    state_nx = CHECK;
`else
                    state_nx = DONE;
`endif
                end
            end
            CHECK:   state_nx = DONE;
            DONE:    if (regen) state_nx = CALC;
            default: state_nx = CALC;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CALC;
        end else begin
            state <= state_nx;
        end
    end

    // Work register, entry index and step counter. Each entry starts from
    // its index in the top byte; idx wraps 8'hFF->0 exactly as CALC ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx  <= '0;
            step <= '0;
            work <= 32'h0;
        end else begin
            case (state)
                CALC: begin
                    if (step == STEP_LAST) begin
                        idx  <= idx_inc;
                        step <= '0;
                        work <= {idx_inc, 24'h0};
                    end else begin
                        step <= step + 4'd1;
                        work <= work_next;
                    end
                end
                DONE: begin
                    if (regen) begin
                        idx  <= '0;
                        step <= '0;
                        work <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table storage has no reset; contents are meaningless until done=1.
    always_ff @(posedge clk) begin
        if (entry_end) begin
            mem[idx] <= work_next;
        end
    end

`ifdef CRCTAB_GEN_SELFCHECK_EN
    logic chk_err_q;

    // Entry 0 must be zero and entry 1 must equal the polynomial itself.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chk_err_q <= 1'b0;
        end else if (state == CHECK) begin
            if ((mem[8'h00] != 32'h0) || (mem[8'h01] != POLY)) begin
                chk_err_q <= 1'b1;
            end
        end else if ((state == DONE) && regen) begin
            chk_err_q <= 1'b0;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

    assign done      = (state == DONE);
    assign busy      = (state != DONE);
    assign rdata     = done ? mem[addr[TAB_ADDR_BITS-1:0]] : 32'h0;
    assign state_dbg = state;

endmodule

// File: tb/tb_crctab_gen.sv
module tb_crctab_gen;

`ifdef CRCTAB_GEN_SELFCHECK_EN
    localparam int LAT  = 2049;
    localparam int LAT8 = 257;
`else
    localparam int LAT  = 2048;
    localparam int LAT8 = 256;
`endif

    // clock / reset block
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        regen = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] rdata;
    logic        done, busy, chk_err;
    logic [1:0]  state_dbg;

    logic        rstn8 = 1'b0;
    logic        regen8 = 1'b0;
    logic [31:0] addr8 = 32'h0;
    logic [31:0] rdata8;
    logic        done8, busy8, chk_err8;
    logic [1:0]  state_dbg8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crctab_gen #(.POLY(32'h04C11DB7), .BPC(1)) u_dut (
        .clk(clk), .rstn(rstn), .regen(regen), .addr(addr), .rdata(rdata),
        .done(done), .busy(busy), .chk_err(chk_err), .state_dbg(state_dbg)
    );

    crctab_gen #(.POLY(32'h04C11DB7), .BPC(8)) u_dut8 (
        .clk(clk), .rstn(rstn8), .regen(regen8), .addr(addr8), .rdata(rdata8),
        .done(done8), .busy(busy8), .chk_err(chk_err8), .state_dbg(state_dbg8)
    );

    // reference table entry: plain bitwise MSB-first CRC-32 of one byte
    function automatic logic [31:0] ref_entry(input int b);
        logic [31:0] w;
        w = 32'(b) << 24;
        for (int k = 0; k < 8; k++) begin
            if (w[31]) w = (w << 1) ^ 32'h04C11DB7;
            else       w = w << 1;
        end
        return w;
    endfunction

    // scoreboard: expected table queue filled from the reference model
    logic [31:0] exp_q[$];

    task automatic sweep_main(input string name);
        exp_q = {};
        for (int a = 0; a < 256; a++) exp_q.push_back(ref_entry(a));
        for (int a = 0; a < 256; a++) begin
            logic [31:0] exp_v;
            @(posedge clk); #2;
            addr = 32'(a);
            #2;
            exp_v = exp_q.pop_front();
            checks++;
            if (rdata !== exp_v) begin
                errors++;
                $display("FAIL %s addr=%0h got=%h exp=%h", name, a, rdata, exp_v);
            end
        end
    endtask

    // driver: wait n edges then sample 1ns later
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_done_edge(input string name, input int lat);
        edges(lat - 1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_early done=%b busy=%b exp done=0 busy=1", name, done, busy);
        end
        edges(1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_rise done=%b busy=%b exp done=1 busy=0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        addr = 32'h1;
        edges(3);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
        checks++;
        if (chk_err !== 1'b0) begin errors++; $display("FAIL rst_chk_err got=%b exp=0", chk_err); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
        checks++;
        if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
    endtask

    // release reset, probe during generation, ignored regen, exact done edge
    task automatic test_generate;
        rstn = 1'b1;               // released at #1 after an edge; next edge is edge 1
        addr = 32'h1;
        edges(10);                 // after edge 10
        checks++;
        if (rdata !== 32'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_read rdata=%h done=%b exp rdata=0 done=0", rdata, done);
        end
        edges(89);                 // after edge 99
        regen = 1'b1;
        edges(1);                  // edge 100 samples regen in CALC
        regen = 1'b0;
        checks++;
        if (done !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL regen_ignored done=%b state=%0d exp done=0 state=0", done, state_dbg);
        end
        // edges(LAT-1) from here must land at edge LAT-1
        edges(LAT - 1 - 100);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL gen_early done=%b exp=0", done); end
        edges(1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gen_rise done=%b busy=%b exp done=1 busy=0", done, busy);
        end
        addr = 32'h01; #1; checks++;
        if (rdata !== 32'h04C11DB7) begin errors++; $display("FAIL vec_01 got=%h exp=04c11db7", rdata); end
        addr = 32'h80; #1; checks++;
        if (rdata !== 32'h690CE0EE) begin errors++; $display("FAIL vec_80 got=%h exp=690ce0ee", rdata); end
        addr = 32'hFF; #1; checks++;
        if (rdata !== 32'hB1F740B4) begin errors++; $display("FAIL vec_ff got=%h exp=b1f740b4", rdata); end
        addr = 32'h4C; #1; checks++;
        if (rdata !== 32'h018AEB13) begin errors++; $display("FAIL vec_4c got=%h exp=018aeb13", rdata); end
        addr = 32'hFFFF_FF10; #1; checks++;
        if (rdata !== 32'h4C11DB70) begin errors++; $display("FAIL addr_hi got=%h exp=4c11db70", rdata); end
        checks++;
        if (chk_err !== 1'b0) begin errors++; $display("FAIL gen_chk_err got=%b exp=0", chk_err); end
        sweep_main("sweep_reset_build");
    endtask

    task automatic test_regen;
        edges(1);
        regen = 1'b1;
        edges(1);                  // edge 0 of the rebuild
        regen = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL regen_drop done=%b busy=%b rdata=%h exp 0 1 0", done, busy, rdata);
        end
        check_done_edge("regen", LAT);
        sweep_main("sweep_regen");
    endtask

    task automatic test_reset_mid;
        edges(1);
        regen = 1'b1;
        edges(1);
        regen = 1'b0;
        edges(1000);
        rstn = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset done=%b busy=%b state=%0d exp 0 1 0", done, busy, state_dbg);
        end
        edges(3);
        rstn = 1'b1;
        check_done_edge("mid_reset", LAT);
        sweep_main("sweep_mid_reset");
    endtask

    task automatic test_bpc8;
        rstn8 = 1'b1;
`ifdef CRCTAB_GEN_SELFCHECK_EN
        edges(LAT8 - 1);
`else
        edges(LAT8 - 1);
`endif
        checks++;
        if (done8 !== 1'b0) begin errors++; $display("FAIL bpc8_early done=%b exp=0", done8); end
        edges(1);
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL bpc8_rise done=%b busy=%b exp done=1 busy=0", done8, busy8);
        end
        checks++;
        if (chk_err8 !== 1'b0) begin errors++; $display("FAIL bpc8_chk_err got=%b exp=0", chk_err8); end
        for (int a = 0; a < 256; a += 17) begin
            addr8 = 32'(a);
            #1;
            checks++;
            if (rdata8 !== ref_entry(a)) begin
                errors++;
                $display("FAIL bpc8_read addr=%0h got=%h exp=%h", a, rdata8, ref_entry(a));
            end
        end
`ifdef CRCTAB_GEN_SELFCHECK_EN
        edges(1);
        regen8 = 1'b1;
        edges(1);
        regen8 = 1'b0;
        edges(10);                 // entry 1 already written at rebuild edge 2
        u_dut8.mem[1] = 32'hDEADBEEF;
        edges(LAT8 - 10);
        checks++;
        if (done8 !== 1'b1 || chk_err8 !== 1'b1) begin
            errors++;
            $display("FAIL bpc8_corrupt done=%b chk_err=%b exp 1 1", done8, chk_err8);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_generate;
        test_regen;
        test_reset_mid;
        test_bpc8;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
